// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the PC and drives a request/ready handshake to instruction memory.
// It presents one instruction per cycle with zero-wait memory. It holds a
// returned instruction while IF/ID is stalled. After an ID-stage redirect it
// drains a stale in-flight request. It emits an all-zero bubble whenever no
// valid instruction is available.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   IF_ID_write            1 = IF/ID takes this cycle's output, 0 = stall
//   redirect_valid/_target branch/jump from ID; overrides everything
//   imem_req/imem_addr     memory request, address held until imem_ready
//   imem_ready/imem_rdata  request completion and instruction data
//   instruction_out        instruction to IF/ID (0 on bubble)
//   pc_plus_4_out          fetch address + 4 (0 on bubble)
//   pc_page_out            pc_plus_4_out[31:28] (0 on bubble)
//   fetch_valid            instruction_out is a real instruction
//
// Optional feature, macro FETCH_PERF_CNT_EN: adds fetch_count and
// bubble_count. These are wrapping 32-bit event counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IF_ID_write,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction_out,
    output logic [ADDR_W-1:0] pc_plus_4_out,
    output logic [3:0]        pc_page_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       bubble_count,
`endif
    output logic              fetch_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0] next_addr;

    // In S_HOLD, req_addr_q still names the held instruction. The same
    // +4 therefore serves both the live path and the held path.
    assign next_addr = req_addr_q + 32'd4;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        req_addr_d      = req_addr_q;
        hold_instr_d    = hold_instr_q;
        imem_req        = 1'b0;
        fetch_valid     = 1'b0;
        instruction_out = 32'h0;
        pc_plus_4_out   = '0;

        case (state_q)
            S_IDLE: begin
                state_d    = S_REQ;
                req_addr_d = pc_q;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    fetch_valid     = 1'b1;
                    instruction_out = imem_rdata;
                    pc_plus_4_out   = next_addr;
                    if (IF_ID_write) begin
                        pc_d       = next_addr;
                        req_addr_d = next_addr;
                    end else begin
                        hold_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                fetch_valid     = 1'b1;
                instruction_out = hold_instr_q;
                pc_plus_4_out   = next_addr;
                if (IF_ID_write) begin
                    pc_d       = next_addr;
                    req_addr_d = next_addr;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                // The stale request must complete before a new address goes out.
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d    = S_REQ;
                    req_addr_d = pc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid) begin
            fetch_valid     = 1'b0;
            instruction_out = 32'h0;
            pc_plus_4_out   = '0;
            hold_instr_d    = hold_instr_q;
            pc_d            = redirect_target;
            // A request that is still in flight must drain first. Otherwise
            // the next request can go straight out at the target address.
            if ((state_q == S_REQ || state_q == S_DROP) && !imem_ready) begin
                state_d    = S_DROP;
                req_addr_d = req_addr_q;
            end else begin
                state_d    = S_REQ;
                req_addr_d = redirect_target;
            end
        end
    end

    assign imem_addr   = imem_req ? req_addr_q : '0;
    assign pc_page_out = pc_plus_4_out[31:28];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            hold_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    // fetch_valid is already forced low on a redirect cycle.
    always_comb begin
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;
        if (fetch_valid && IF_ID_write && !redirect_valid)
            fetch_count_d = fetch_count_q + 32'd1;
        if (!fetch_valid && IF_ID_write)
            bubble_count_d = bubble_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q  <= 32'h0;
            bubble_count_q <= 32'h0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule
